// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types, default parameters and command-to-duty decode for the PWM motor block.
package pwm_pkg;
  typedef logic signed [15:0] cmd_t;
  typedef logic [15:0] duty_t;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_PERIOD = 1000;
  localparam int DEF_RAMP_STEP = 10;
  localparam cmd_t DEF_CMD_INIT = 16'sd100;
  // Widening to int before negation lets -32768 become 32768 before the clamp.
  function automatic duty_t target_duty(input cmd_t cmd, input int period);
    int mag;
    mag = (cmd < 0) ? -int'(cmd) : int'(cmd);
    return duty_t'((mag > period) ? period : mag);
  endfunction
endpackage

// File: rtl/pwm_core.sv
// pwm_core: prescaler, period counter, boundary-latched duty and registered comparator.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  duty_t duty_i,
  input  duty_t rst_duty_i,
  output logic  start_o,
  output logic  spd_o
);
  localparam duty_t DIV_M1 = duty_t'(CLK_DIV - 1);
  localparam duty_t PER_M1 = duty_t'(PERIOD - 1);
  duty_t pre_q, pre_d, cnt_q, cnt_d, duty_q, duty_d;
  logic spd_q, spd_d, tick, wrap;
  always_comb begin
    tick = pre_q == DIV_M1;
    wrap = tick && cnt_q == PER_M1;
    pre_d = tick ? '0 : pre_q + 16'd1;
    cnt_d = wrap ? '0 : tick ? cnt_q + 16'd1 : cnt_q;
    duty_d = wrap ? duty_i : duty_q;
    spd_d = cnt_q < duty_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q <= '0;
      cnt_q <= '0;
      duty_q <= rst_duty_i;
      spd_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      duty_q <= duty_d;
      spd_q <= spd_d;
    end
  end
  assign start_o = wrap;
  assign spd_o = spd_q;
endmodule

// File: rtl/pwm_wrapper.sv
// pwm_wrapper: decodes the fixed speed command into dir and duty for pwm_core.
// Define PWM_RAMP_EN to soft-start the duty from 0 in RAMP_STEP increments per period.
module pwm_wrapper
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int PERIOD = DEF_PERIOD,
  parameter cmd_t CMD_INIT = DEF_CMD_INIT,
  parameter int RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic CLK100MHZ,
  input  logic rst,
  output logic spd,
  output logic dir
);
  localparam duty_t TARGET = target_duty(CMD_INIT, PERIOD);
  logic start, dir_q;
  duty_t duty_next, duty_rst;
`ifdef PWM_RAMP_EN
  duty_t ramp_q, ramp_d;
  logic [16:0] sum;
  // The core latches ramp_d at the same boundary where ramp_q advances to it.
  always_comb begin
    sum = {1'b0, ramp_q} + 17'(RAMP_STEP);
    ramp_d = (sum > 17'(TARGET)) ? TARGET : sum[15:0];
  end
  always_ff @(posedge CLK100MHZ) ramp_q <= rst ? '0 : start ? ramp_d : ramp_q;
  assign duty_next = ramp_d;
  assign duty_rst = '0;
`else
  assign duty_next = TARGET;
  assign duty_rst = TARGET;
`endif
  // dir only ever reloads at reset or a period boundary, so it cannot glitch mid-period.
  always_ff @(posedge CLK100MHZ) dir_q <= (rst || start) ? CMD_INIT[15] : dir_q;
  pwm_core #(.CLK_DIV(CLK_DIV), .PERIOD(PERIOD)) u_core (
    .clk_i(CLK100MHZ),
    .rst_i(rst),
    .duty_i(duty_next),
    .rst_duty_i(duty_rst),
    .start_o(start),
    .spd_o(spd)
  );
  assign dir = dir_q;
endmodule

// File: tb/tb_pwm_wrapper.sv
// tb_pwm_wrapper: five parameterisations checked per period for high-time and contiguity.
module tb_pwm_wrapper;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] spd_w, dir_w;
  int total = 0, bad = 0;
  typedef struct {string nm; int id; int div; int per; int duty; int nper;} vec_t;
  typedef struct {int hi; int fl;} exp_t;
  exp_t sb[$];
  vec_t tbl[5];
  localparam logic [4:0] DIR_EXP = 5'b10010;

  always #5 clk = ~clk;

  pwm_wrapper u_a (.CLK100MHZ(clk), .rst(rst), .spd(spd_w[0]), .dir(dir_w[0]));
  pwm_wrapper #(.CMD_INIT(-16'sd250), .CLK_DIV(1), .PERIOD(1000)) u_b (
    .CLK100MHZ(clk), .rst(rst), .spd(spd_w[1]), .dir(dir_w[1]));
  pwm_wrapper #(.CMD_INIT(16'sd0)) u_c (.CLK100MHZ(clk), .rst(rst), .spd(spd_w[2]), .dir(dir_w[2]));
  pwm_wrapper #(.CMD_INIT(16'sd5000), .PERIOD(1000)) u_d (
    .CLK100MHZ(clk), .rst(rst), .spd(spd_w[3]), .dir(dir_w[3]));
  pwm_wrapper #(.CMD_INIT(16'sh8000)) u_e (.CLK100MHZ(clk), .rst(rst), .spd(spd_w[4]), .dir(dir_w[4]));

  function automatic int exp_duty(input int t, input int k);
`ifdef PWM_RAMP_EN
    return ((k - 1) * 10 < t) ? (k - 1) * 10 : t;
`else
    return t + 0 * k;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_spd", int'(spd_w), 0);
    chk("rst_dir", int'(dir_w), int'(DIR_EXP));
    rst = 1'b0;
  endtask

  // hi = high samples in the period, fl = index of first low sample.
  task automatic measure(input string nm, input int id, input int div, input int per,
                         input int duty, input int nper);
    for (int k = 1; k <= nper; k++) begin
      exp_t e;
      e.hi = exp_duty(duty, k) * div;
      e.fl = e.hi;
      sb.push_back(e);
    end
    for (int k = 1; k <= nper; k++) begin
      int hi, fl;
      exp_t e;
      hi = 0;
      fl = -1;
      for (int j = 0; j < per * div; j++) begin
        @(negedge clk);
        if (spd_w[id]) hi++;
        else if (fl < 0) fl = j;
      end
      if (fl < 0) fl = per * div;
      e = sb.pop_front();
      chk($sformatf("%s p%0d hi", nm, k), hi, e.hi);
      chk($sformatf("%s p%0d first_low", nm, k), fl, e.fl);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int offs[2];
    tbl[0] = '{"dflt", 0, 4, 1000, 100, 2};
    tbl[1] = '{"neg250", 1, 1, 1000, 250, 3};
    tbl[2] = '{"zero", 2, 4, 1000, 0, 1};
    tbl[3] = '{"sat5000", 3, 4, 1000, 1000, 1};
    tbl[4] = '{"min_neg", 4, 4, 1000, 1000, 1};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      measure(tbl[i].nm, tbl[i].id, tbl[i].div, tbl[i].per, tbl[i].duty, tbl[i].nper);
      chk($sformatf("%s dir", tbl[i].nm), int'(dir_w), int'(DIR_EXP));
    end
    offs[0] = 200;
    offs[1] = 1500;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      repeat (offs[i]) @(negedge clk);
      chk($sformatf("pre_rst@%0d", offs[i]), int'(spd_w[0]), int'(exp_duty(100, 1) * 4 > offs[i] - 1));
      rst = 1'b1;
      @(negedge clk);
      chk($sformatf("mid_rst@%0d spd", offs[i]), int'(spd_w[0]), 0);
      rst = 1'b0;
      measure($sformatf("after_rst@%0d", offs[i]), 0, 4, 1000, 100, 1);
    end
`ifdef PWM_RAMP_EN
    do_reset();
    measure("ramp", 0, 4, 1000, 100, 12);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_wrapper.md
PWM_WRAPPER -- requirements
Module: pwm_wrapper

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per PWM tick; legal range 1..65535.
REQ-002 Parameter PERIOD, default 1000: PWM ticks per PWM period; legal range 2..65535.
REQ-003 Parameter CMD_INIT, default 16'sd100: signed 16-bit speed/direction command driven internally.
REQ-004 Parameter RAMP_STEP, default 10: duty increment per PWM period when ramping is compiled in; 1..65535.
REQ-005 CLK100MHZ  input  1  sole clock, 100 MHz, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 spd  output  1  registered PWM speed output to motor driver.
REQ-008 dir  output  1  registered direction output: 0 forward, 1 reverse.
REQ-009 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high.

Function
REQ-010 Command SHALL be CMD_INIT, signed two's complement; dir = sign bit; magnitude = |CMD_INIT|.
REQ-011 Target duty SHALL be min(magnitude, PERIOD); -32768 SHALL give magnitude 32768, then saturate.
REQ-012 Prescaler SHALL count 0..CLK_DIV-1 and issue a one-clock tick when it reaches CLK_DIV-1; CLK_DIV=1 means a tick every clock.
REQ-013 Period counter SHALL advance on each tick over 0..PERIOD-1, wrapping to 0.
REQ-014 spd SHALL be registered as (period counter < active duty); duty 0 gives constant low, duty >= PERIOD gives constant high.
REQ-015 Active duty SHALL update only at a period boundary (counter wraps to 0), so no period is truncated or glitched.
REQ-016 After reset release with duty > 0, spd SHALL go high on the first rising edge with rst low.
REQ-017 With defaults, no ramping: period = 4000 clocks; spd high 400 clocks, low 3600 clocks, repeating.
REQ-018 dir SHALL be constant after reset and never toggle while rst is low.
REQ-019 Counter arithmetic SHALL use 16-bit unsigned widths; no overflow, since PERIOD <= 65535.

Reset
REQ-020 While rst=1: prescaler=0, period counter=0, spd=0.
REQ-021 While rst=1: dir = sign bit of CMD_INIT.
REQ-022 While rst=1: active duty = target duty without ramping; 0 with ramping.
REQ-023 Reset asserted mid-period SHALL force spd=0 on the next edge and restart a full period after release.

Configuration
REQ-024 Macro PWM_RAMP_EN defined: active duty SHALL start at 0 after reset.
REQ-025 PWM_RAMP_EN defined: at each period boundary, active duty SHALL increase by RAMP_STEP, clamped to target duty, then hold.
REQ-026 PWM_RAMP_EN undefined: active duty SHALL equal target duty from reset onward; no ramp logic is present.

Structure
REQ-027 Package pwm_pkg SHALL hold: typedef cmd_t (signed 16-bit), typedef duty_t (unsigned 16-bit), default constants for CLK_DIV, PERIOD, CMD_INIT, RAMP_STEP.
REQ-028 Sub-module pwm_core SHALL contain prescaler, period counter, boundary-latched duty register and comparator; it exposes a one-clock period-start strobe.
REQ-029 pwm_wrapper SHALL contain command decode (sign, magnitude, saturation), the optional ramp, and the dir register.

Verification
REQ-030 Defaults, ramp off: rst high 1 cycle, then release -> spd high 400 clocks, low 3600, period 4000; dir=0.
REQ-031 CMD_INIT=-250, CLK_DIV=1, PERIOD=1000 -> dir=1; spd high 250 of every 1000 clocks.
REQ-032 CMD_INIT=0 -> spd stays 0; CMD_INIT=5000, PERIOD=1000 -> spd stays 1 after first edge; CMD_INIT=-32768 -> spd stays 1, dir=1.
REQ-033 rst pulsed for 1 cycle at clock 1500 of a period -> spd=0 next edge; new full 400/3600 pattern starts after release.
REQ-034 PWM_RAMP_EN, defaults -> period 1 high 0 ticks; period 2 high 10 ticks (40 clocks); period 3 high 20 ticks; reaches 100 ticks (400 clocks) at period 11, then holds.
REQ-035 Every run: spd changes only on CLK100MHZ rising edges; no high pulse shorter than CLK_DIV clocks unless duty is 0.
